d_merge_ctrl: RTL and testbench

D_MERGE_CTRL -- requirements
Module: d_merge_ctrl

---
 rtl/d_cache_pkg.sv | 20 ++
 rtl/d_split_calc.sv | 20 ++
 rtl/d_merge_ctrl.sv | 106 ++++++++++
 tb/tb_d_merge_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/d_cache_pkg.sv
// d_cache_pkg: shared op/size encodings, line geometry and merge FSM states
package d_cache_pkg;
  typedef enum logic [2:0] {
    OP_NOOP  = 3'd0,
    OP_LD    = 3'd1,
    OP_ST    = 3'd2,
    OP_PF    = 3'd3,
    OP_FLUSH = 3'd4,
    OP_INV   = 3'd5,
    OP_RD_WR = 3'd6,
    OP_WR_LD = 3'd7
  } op_t;
  typedef enum logic [1:0] {SZ_1B, SZ_2B, SZ_3B, SZ_4B} sz_t;
  localparam int CL_BYTES = 16;
  localparam int CL_BITS = $clog2(CL_BYTES);
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RESP, S_WAIT, S_DONE} state_t;
  function automatic logic is_mem_op(input logic [2:0] op);
    return op == OP_LD || op == OP_ST;
  endfunction
endpackage

// File: rtl/d_split_calc.sv
// d_split_calc: line pair, line-crossing and even/odd bank selection for one request
module d_split_calc import d_cache_pkg::*; (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic [31:0] e_addr,
  output logic [31:0] o_addr,
  output logic        need_p1,
  output logic        use_e_as_0
);
  logic [31:0] line0, line1;
  logic [CL_BITS:0] end_off;
  assign line0 = {addr[31:CL_BITS], {CL_BITS{1'b0}}};
  assign line1 = line0 + 32'(CL_BYTES);
  // last byte offset overflowing the line means the access spills into line1
  assign end_off = {1'b0, addr[CL_BITS-1:0]} + {{(CL_BITS-1){1'b0}}, size};
  assign need_p1 = end_off[CL_BITS];
  assign use_e_as_0 = ~addr[CL_BITS];
  assign e_addr = line0[CL_BITS] ? line1 : line0;
  assign o_addr = line0[CL_BITS] ? line0 : line1;
endmodule

// File: rtl/d_merge_ctrl.sv
// d_merge_ctrl: strobes even/odd bank lookups for an access and replays until all needed lines hit together
module d_merge_ctrl import d_cache_pkg::*; #(
  parameter int OOO_TAG_SIZE = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic [1:0]              req_size,
  input  logic [2:0]              req_op,
  input  logic                    req_sext,
  input  logic [OOO_TAG_SIZE-1:0] req_tag,
  output logic                    e_lookup_valid,
  output logic [31:0]             e_lookup_addr,
  output logic                    o_lookup_valid,
  output logic [31:0]             o_lookup_addr,
  input  logic                    hit_e,
  input  logic                    hit_o,
  input  logic                    wake_e,
  input  logic                    wake_o,
  output logic                    use_e_as_0,
  output logic                    need_p1,
  output logic [1:0]              size_out,
  output logic                    sext_out,
  output logic [OOO_TAG_SIZE-1:0] tag_out,
  output logic                    done_valid,
  input  logic                    done_ready
);
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_t state;
  logic miss_e, miss_o, woke_e, woke_o;
  logic [7:0] cnt;
  logic [2:0] op_q;
  logic [31:0] c_e_addr, c_o_addr;
  logic c_need_p1, c_use_e;
  logic need_e, need_o, resp_miss_e, resp_miss_o, woke_e_n, woke_o_n, replay;
  d_split_calc u_split (
    .addr(req_addr),
    .size(req_size),
    .e_addr(c_e_addr),
    .o_addr(c_o_addr),
    .need_p1(c_need_p1),
    .use_e_as_0(c_use_e)
  );
  assign req_ready = state == S_IDLE;
  assign done_valid = state == S_DONE;
  assign need_e = use_e_as_0 | need_p1;
  assign need_o = ~use_e_as_0 | need_p1;
  assign e_lookup_valid = state == S_LOOKUP && need_e;
  assign o_lookup_valid = state == S_LOOKUP && need_o;
  assign resp_miss_e = need_e & ~hit_e;
  assign resp_miss_o = need_o & ~hit_o;
  assign woke_e_n = woke_e | (wake_e & miss_e);
  assign woke_o_n = woke_o | (wake_o & miss_o);
  // a wake landing on the timeout cycle still yields just one replay
  assign replay = ((~miss_e | woke_e_n) & (~miss_o | woke_o_n)) | (cnt == TMO);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      {miss_e, miss_o, woke_e, woke_o} <= '0;
      cnt <= '0;
      op_q <= '0;
      e_lookup_addr <= '0;
      o_lookup_addr <= '0;
      need_p1 <= 1'b0;
      use_e_as_0 <= 1'b0;
      size_out <= '0;
      sext_out <= 1'b0;
      tag_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid && is_mem_op(req_op)) begin
          op_q <= req_op;
          e_lookup_addr <= c_e_addr;
          o_lookup_addr <= c_o_addr;
          need_p1 <= c_need_p1;
          use_e_as_0 <= c_use_e;
          size_out <= req_size;
          sext_out <= req_sext;
          tag_out <= req_tag;
          state <= S_LOOKUP;
        end
        S_LOOKUP: state <= S_RESP;
        S_RESP: if (resp_miss_e | resp_miss_o) begin
          miss_e <= resp_miss_e;
          miss_o <= resp_miss_o;
          {woke_e, woke_o} <= '0;
          cnt <= '0;
          state <= S_WAIT;
        end else state <= S_DONE;
        S_WAIT: begin
          woke_e <= woke_e_n;
          woke_o <= woke_o_n;
          cnt <= replay ? 8'd0 : cnt + 8'd1;
          state <= replay ? S_LOOKUP : S_WAIT;
        end
        S_DONE: if (done_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!rst && state != S_IDLE) assert (is_mem_op(op_q));
endmodule

// File: tb/tb_d_merge_ctrl.sv
// tb_d_merge_ctrl: directed and randomized checks of d_merge_ctrl against an address/timing model
module tb_d_merge_ctrl;
  import d_cache_pkg::*;
  localparam int TW = 10;
  localparam int TO = 255;
  logic clk = 0, rst = 1, req_valid = 0, req_sext = 0;
  logic hit_e = 0, hit_o = 0, wake_e = 0, wake_o = 0, done_ready = 0;
  logic [31:0] req_addr = 0;
  logic [1:0] req_size = 0;
  logic [2:0] req_op = 0;
  logic [TW-1:0] req_tag = 0;
  logic req_ready, e_lookup_valid, o_lookup_valid, use_e_as_0, need_p1, sext_out, done_valid;
  logic [31:0] e_lookup_addr, o_lookup_addr;
  logic [1:0] size_out;
  logic [TW-1:0] tag_out;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  d_merge_ctrl #(.OOO_TAG_SIZE(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_op(req_op), .req_sext(req_sext),
    .req_tag(req_tag), .e_lookup_valid(e_lookup_valid), .e_lookup_addr(e_lookup_addr),
    .o_lookup_valid(o_lookup_valid), .o_lookup_addr(o_lookup_addr), .hit_e(hit_e),
    .hit_o(hit_o), .wake_e(wake_e), .wake_o(wake_o), .use_e_as_0(use_e_as_0),
    .need_p1(need_p1), .size_out(size_out), .sext_out(sext_out), .tag_out(tag_out),
    .done_valid(done_valid), .done_ready(done_ready)
  );

  function automatic logic [31:0] m_line(input logic [31:0] a, input logic [31:0] k);
    return (a / 32'd16 + k) * 32'd16;
  endfunction
  function automatic logic m_cross(input logic [31:0] a, input logic [1:0] s);
    return int'(a % 32'd16) + int'(s) > 15;
  endfunction
  function automatic logic m_first_even(input logic [31:0] a);
    return (a / 32'd16) % 32'd2 == 0;
  endfunction
  function automatic logic [31:0] m_e_addr(input logic [31:0] a);
    return m_first_even(a) ? m_line(a, 0) : m_line(a, 1);
  endfunction
  function automatic logic [31:0] m_o_addr(input logic [31:0] a);
    return m_first_even(a) ? m_line(a, 1) : m_line(a, 0);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_req(input logic [31:0] a, input logic [1:0] s, input logic [2:0] op,
                          input logic sx, input logic [TW-1:0] t);
    req_valid = 1; req_addr = a; req_size = s; req_op = op; req_sext = sx; req_tag = t;
    tick();
    req_valid = 0; req_op = 0;
  endtask
  task automatic respond(input logic he, input logic ho);
    tick();
    hit_e = he; hit_o = ho;
    tick();
    hit_e = 0; hit_o = 0;
  endtask
  // w counts WAIT cycles from entry until a strobe is seen; -1 if none within the budget
  task automatic wait_wakes(input int we, input int wo, output int w);
    w = -1;
    for (int i = 0; i <= TO + 20; i++) begin
      if (e_lookup_valid || o_lookup_valid) begin w = i; break; end
      wake_e = (i == we); wake_o = (i == wo);
      tick();
    end
    wake_e = 0; wake_o = 0;
  endtask
  task automatic release_done(input int bp);
    done_ready = 0; tick(bp); done_ready = 1; tick(); done_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(2);
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", req_ready); else passed++;
    checks++;
    if ({e_lookup_valid, e_lookup_addr, o_lookup_valid, o_lookup_addr, use_e_as_0, need_p1,
         size_out, sext_out, tag_out, done_valid} !== '0)
      $display("FAIL reset_outputs: got e=%b/%h o=%b/%h ue=%b np=%b sz=%0d sx=%b tag=%h dv=%b exp all 0",
               e_lookup_valid, e_lookup_addr, o_lookup_valid, o_lookup_addr, use_e_as_0, need_p1,
               size_out, sext_out, tag_out, done_valid);
    else passed++;
    rst = 0; tick();
  endtask

  task automatic test_aligned_hit();
    send_req(32'h100, 2'd3, OP_LD, 1'b0, 10'h3A);
    checks++; if ({need_p1, use_e_as_0} !== 2'b01) $display("FAIL aligned_split: got np/ue=%b%b exp 01", need_p1, use_e_as_0); else passed++;
    checks++; if (e_lookup_addr !== 32'h100) $display("FAIL aligned_eaddr: got %h exp 00000100", e_lookup_addr); else passed++;
    checks++; if ({e_lookup_valid, o_lookup_valid} !== 2'b10) $display("FAIL aligned_strobe: got %b%b exp 10", e_lookup_valid, o_lookup_valid); else passed++;
    tick(); hit_e = 1; hit_o = 1;
    checks++; if (done_valid !== 1'b0) $display("FAIL aligned_early_done: got %b exp 0 at cycle 2", done_valid); else passed++;
    tick(); hit_e = 0; hit_o = 0;
    checks++; if (done_valid !== 1'b1) $display("FAIL aligned_latency: got %b exp 1 at cycle 3", done_valid); else passed++;
    release_done(0);
  endtask

  task automatic test_crossing_hit();
    send_req(32'h11E, 2'd3, OP_LD, 1'b1, 10'h155);
    checks++; if ({need_p1, use_e_as_0} !== 2'b10) $display("FAIL cross_split: got np/ue=%b%b exp 10", need_p1, use_e_as_0); else passed++;
    checks++; if ({e_lookup_addr, o_lookup_addr} !== {32'h120, 32'h110}) $display("FAIL cross_addr: got e=%h o=%h exp e=00000120 o=00000110", e_lookup_addr, o_lookup_addr); else passed++;
    checks++; if ({e_lookup_valid, o_lookup_valid} !== 2'b11) $display("FAIL cross_strobe: got %b%b exp 11", e_lookup_valid, o_lookup_valid); else passed++;
    respond(1, 1);
    checks++; if (done_valid !== 1'b1) $display("FAIL cross_done: got %b exp 1", done_valid); else passed++;
    release_done(0);
  endtask

  task automatic test_split_miss();
    int w;
    send_req(32'h10E, 2'd3, OP_LD, 1'b0, 10'h0F0);
    checks++; if ({e_lookup_addr, o_lookup_addr} !== {32'h100, 32'h110}) $display("FAIL split_addr: got e=%h o=%h exp e=00000100 o=00000110", e_lookup_addr, o_lookup_addr); else passed++;
    respond(1, 0);
    checks++; if ({done_valid, req_ready, e_lookup_valid, o_lookup_valid} !== 4'b0000) $display("FAIL split_wait_state: got dv/rdy/e/o=%b%b%b%b exp 0000", done_valid, req_ready, e_lookup_valid, o_lookup_valid); else passed++;
    wait_wakes(-1, 20, w);
    checks++; if (w !== 21) $display("FAIL split_replay_cycle: got %0d exp 21", w); else passed++;
    checks++; if ({e_lookup_valid, o_lookup_valid} !== 2'b11) $display("FAIL split_replay_strobe: got %b%b exp 11", e_lookup_valid, o_lookup_valid); else passed++;
    respond(1, 1);
    checks++; if (done_valid !== 1'b1) $display("FAIL split_done: got %b exp 1", done_valid); else passed++;
    release_done(1);
  endtask

  task automatic test_timeout();
    int w;
    send_req(32'h200, 2'd0, OP_ST, 1'b0, 10'h011);
    respond(0, 0);
    wait_wakes(-1, 3, w);
    checks++; if (w !== TO + 1) $display("FAIL timeout_cycle: got %0d exp %0d", w, TO + 1); else passed++;
    checks++; if ({e_lookup_valid, o_lookup_valid} !== 2'b10) $display("FAIL timeout_strobe: got %b%b exp 10", e_lookup_valid, o_lookup_valid); else passed++;
    respond(1, 1);
    checks++; if (done_valid !== 1'b1) $display("FAIL timeout_done: got %b exp 1", done_valid); else passed++;
    release_done(0);
  endtask

  task automatic test_wrap_backpressure();
    send_req(32'hFFFF_FFFF, 2'd1, OP_LD, 1'b1, 10'h2AB);
    checks++; if ({need_p1, use_e_as_0} !== 2'b10) $display("FAIL wrap_split: got np/ue=%b%b exp 10", need_p1, use_e_as_0); else passed++;
    checks++; if ({e_lookup_valid, o_lookup_valid} !== 2'b11) $display("FAIL wrap_strobe: got %b%b exp 11", e_lookup_valid, o_lookup_valid); else passed++;
    respond(1, 1);
    done_ready = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({done_valid, e_lookup_addr, o_lookup_addr, size_out, sext_out, tag_out} !==
          {1'b1, 32'h0, 32'hFFFF_FFF0, 2'd1, 1'b1, 10'h2AB})
        $display("FAIL wrap_hold[%0d]: got dv=%b e=%h o=%h sz=%0d sx=%b tag=%h exp dv=1 e=00000000 o=fffffff0 sz=1 sx=1 tag=2ab",
                 i, done_valid, e_lookup_addr, o_lookup_addr, size_out, sext_out, tag_out);
      else passed++;
      tick();
    end
    done_ready = 1; tick(); done_ready = 0;
    checks++; if ({req_ready, done_valid} !== 2'b10) $display("FAIL wrap_handshake: got rdy/dv=%b%b exp 10", req_ready, done_valid); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    send_req(32'h300, 2'd3, OP_LD, 1'b1, 10'h3FF);
    respond(0, 0);
    tick(5);
    rst = 1; tick(); rst = 0;
    checks++; if ({req_ready, e_lookup_valid, o_lookup_valid, done_valid} !== 4'b1000) $display("FAIL rstwait_state: got rdy/e/o/dv=%b%b%b%b exp 1000", req_ready, e_lookup_valid, o_lookup_valid, done_valid); else passed++;
    checks++; if ({e_lookup_addr, o_lookup_addr, use_e_as_0, need_p1, size_out, sext_out, tag_out} !== '0) $display("FAIL rstwait_outputs: got e=%h o=%h ue=%b sz=%0d tag=%h exp all 0", e_lookup_addr, o_lookup_addr, use_e_as_0, size_out, tag_out); else passed++;
    wake_e = 1; wake_o = 1; tick(); wake_e = 0; wake_o = 0; tick(3);
    checks++; if ({req_ready, e_lookup_valid, o_lookup_valid} !== 3'b100) $display("FAIL rstwait_late_wake: got rdy/e/o=%b%b%b exp 100", req_ready, e_lookup_valid, o_lookup_valid); else passed++;
  endtask

  task automatic test_drop_op();
    for (int op = 0; op < 8; op++) begin
      if (op == 1 || op == 2) continue;
      send_req(32'h440, 2'd0, 3'(op), 1'b0, 10'h001);
      checks++; if ({req_ready, e_lookup_valid, o_lookup_valid} !== 3'b100) $display("FAIL drop_op%0d: got rdy/e/o=%b%b%b exp 100", op, req_ready, e_lookup_valid, o_lookup_valid); else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [1:0] s;
      logic [TW-1:0] t;
      logic sx, ne, no, he, ho, m_e, m_o;
      int we, wo, w, exp_w, me_w, mo_w, bp;
      a = $urandom;
      if (n % 3 == 0) a[3:0] = 4'hC + 4'($urandom_range(0, 3));
      if (n % 7 == 0) a[31:4] = '1;
      s = 2'($urandom_range(0, 3));
      sx = 1'($urandom);
      t = TW'($urandom);
      ne = m_first_even(a) || m_cross(a, s);
      no = !m_first_even(a) || m_cross(a, s);
      checks++; if (req_ready !== 1'b1) $display("FAIL rand_ready[%0d]: got %b exp 1", n, req_ready); else passed++;
      send_req(a, s, (n % 2) ? OP_ST : OP_LD, sx, t);
      checks++; if ({need_p1, use_e_as_0} !== {m_cross(a, s), m_first_even(a)}) $display("FAIL rand_split[%0d]: a=%h s=%0d got np/ue=%b%b exp %b%b", n, a, s, need_p1, use_e_as_0, m_cross(a, s), m_first_even(a)); else passed++;
      checks++; if ({e_lookup_addr, o_lookup_addr} !== {m_e_addr(a), m_o_addr(a)}) $display("FAIL rand_addr[%0d]: a=%h got e=%h o=%h exp e=%h o=%h", n, a, e_lookup_addr, o_lookup_addr, m_e_addr(a), m_o_addr(a)); else passed++;
      checks++; if ({size_out, sext_out, tag_out} !== {s, sx, t}) $display("FAIL rand_latch[%0d]: got sz=%0d sx=%b tag=%h exp sz=%0d sx=%b tag=%h", n, size_out, sext_out, tag_out, s, sx, t); else passed++;
      for (int r = 0; r < 4; r++) begin
        checks++; if ({e_lookup_valid, o_lookup_valid} !== {ne, no}) $display("FAIL rand_strobe[%0d.%0d]: got %b%b exp %b%b", n, r, e_lookup_valid, o_lookup_valid, ne, no); else passed++;
        he = (r == 3) || ($urandom_range(0, 3) != 0);
        ho = (r == 3) || ($urandom_range(0, 3) != 0);
        respond(he, ho);
        m_e = ne && !he;
        m_o = no && !ho;
        checks++; if (done_valid !== !(m_e || m_o)) $display("FAIL rand_resp[%0d.%0d]: got dv=%b exp %b", n, r, done_valid, !(m_e || m_o)); else passed++;
        if (!(m_e || m_o)) break;
        we = $urandom_range(0, 30);
        wo = $urandom_range(0, 30);
        if ($urandom_range(0, 24) == 0) begin
          if (m_e) we = -1; else wo = -1;
        end
        me_w = m_e ? we + 1 : 0;
        mo_w = m_o ? wo + 1 : 0;
        exp_w = (me_w > mo_w) ? me_w : mo_w;
        if ((m_e && we < 0) || (m_o && wo < 0) || exp_w > TO + 1) exp_w = TO + 1;
        wait_wakes(we, wo, w);
        checks++; if (w !== exp_w) $display("FAIL rand_replay[%0d.%0d]: got %0d exp %0d (we=%0d wo=%0d)", n, r, w, exp_w, we, wo); else passed++;
      end
      bp = $urandom_range(0, 3);
      done_ready = 0;
      for (int i = 0; i < bp; i++) begin
        checks++; if ({done_valid, tag_out} !== {1'b1, t}) $display("FAIL rand_hold[%0d]: got dv=%b tag=%h exp dv=1 tag=%h", n, done_valid, tag_out, t); else passed++;
        tick();
      end
      done_ready = 1; tick(); done_ready = 0;
      checks++; if ({req_ready, done_valid} !== 2'b10) $display("FAIL rand_turnaround[%0d]: got rdy/dv=%b%b exp 10", n, req_ready, done_valid); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_aligned_hit();
    test_crossing_hit();
    test_split_miss();
    test_timeout();
    test_wrap_backpressure();
    test_reset_mid_wait();
    test_drop_op();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
